fetch_resp: RTL and testbench
=============================

FETCH_RESP -- requirements
Module: fetch_resp

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the memory word-address width (mem_addr = core_addr[ADDR_W+1:2]).
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum cycles spent in REQ waiting for mem_ready.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 core_req  in  1  fetch request from the IF stage, held while core_stall=1.
REQ-006 core_addr  in  32  fetch PC.
REQ-007 core_flush  in  1  branch/trap redirect; discards any in-flight fetch.
REQ-008 core_instr  out  32  returned instruction.
REQ-009 core_valid  out  1  core_instr valid, one-cycle pulse.
REQ-010 core_stall  out  1  IF SHALL hold PC and IF/ID while high.
REQ-011 core_err  out  1  one-cycle pulse with core_valid on misalign or timeout.
REQ-012 mem_cs  out  1  memory read request.
REQ-013 mem_addr  out  ADDR_W  word address.
REQ-014 mem_rdata  in  32  read data, sampled when mem_ready=1.
REQ-015 mem_ready  in  1  read-complete handshake.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP, DROP.
REQ-017 IDLE, core_req=1, core_flush=0, core_addr[1:0]=0: latch the address, enter REQ next cycle.
REQ-018 In REQ: mem_cs=1 and mem_addr from the latched address, held stable until mem_ready.
REQ-019 In REQ, mem_ready=1: capture mem_rdata and enter RESP next cycle; minimum latency from core_req to core_valid SHALL be 2 cycles.
REQ-020 In RESP: core_valid=1, core_instr=captured data, core_stall=0.
REQ-021 In RESP with a new core_req: behave as IDLE (back-to-back issue); otherwise return to IDLE.
REQ-022 core_stall SHALL equal (state==REQ) | (state==DROP) | (state==IDLE & core_req & ~core_flush).
REQ-023 A misaligned core_addr (bits [1:0] != 0) SHALL NOT assert mem_cs; it goes to RESP with core_instr=NOP (32'h00000013) and core_err=1.
REQ-024 The REQ cycle counter SHALL count from 0. On reaching TIMEOUT without mem_ready: mem_cs drops, RESP with NOP and core_err=1.
REQ-025 core_flush in REQ: enter DROP. DROP keeps mem_cs=0, waits for mem_ready or TIMEOUT, then goes to IDLE with no core_valid.
REQ-026 core_flush in IDLE or RESP: that cycle's core_req is ignored and core_valid is suppressed.
REQ-027 mem_ready outside REQ/DROP SHALL be ignored.

Reset
REQ-028 On rst (synchronous): state=IDLE, counter=0, core_instr=0, core_valid=0, core_err=0, core_stall=0, mem_cs=0, mem_addr=0.
REQ-029 rst mid-REQ SHALL abandon the fetch with no core_valid and no later response.

Configuration
REQ-030 Macro FETCH_BUF_EN defined: a one-entry last-fetch buffer (tag = word address, data, valid). An IDLE request that hits goes to RESP next cycle with mem_cs never asserted (1-cycle latency). The buffer fills on every successful REQ completion and is invalidated on rst or timeout.
REQ-031 Macro FETCH_BUF_EN undefined: every aligned request goes through REQ and no buffer storage exists.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum typedef, the NOP constant, and the TIMEOUT default.
REQ-033 The buffer SHALL be sub-module fetch_buf, instantiated only under FETCH_BUF_EN.

Verification
REQ-034 core_addr=32'h100, mem_ready one cycle after mem_cs, mem_rdata=32'h00500093 -> mem_addr=14'h040, core_valid and core_instr=32'h00500093 three cycles after core_req.
REQ-035 core_addr=32'h102 -> no mem_cs; core_valid with core_instr=32'h00000013 and core_err=1.
REQ-036 mem_ready never asserted, TIMEOUT=15 -> mem_cs high 15 cycles, then core_err=1 with NOP.
REQ-037 core_flush in the 2nd REQ cycle, mem_ready 3 cycles later -> no core_valid, state returns to IDLE, core_stall low afterward.
REQ-038 With FETCH_BUF_EN, fetch 32'h100 twice -> the second fetch has no mem_cs and core_valid 1 cycle after core_req, with the same data.
REQ-039 rst asserted mid-REQ -> all outputs at reset values next cycle, and no late core_valid when mem_ready arrives.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch response block.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned ADDR_W_DEF  = 14;

endpackage

// File: rtl/fetch_resp_if.sv
// Core-side fetch handshake and memory read port bundled for fetch_resp.
interface fetch_resp_if #(
  parameter int unsigned ADDR_W = fetch_pkg::ADDR_W_DEF
);
  logic              core_req;
  logic [31:0]       core_addr;
  logic              core_flush;
  logic [31:0]       core_instr;
  logic              core_valid;
  logic              core_stall;
  logic              core_err;
  logic              mem_cs;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  core_req, core_addr, core_flush, mem_rdata, mem_ready,
    output core_instr, core_valid, core_stall, core_err, mem_cs, mem_addr
  );

  modport master (
    output core_req, core_addr, core_flush, mem_rdata, mem_ready,
    input  core_instr, core_valid, core_stall, core_err, mem_cs, mem_addr
  );
endinterface

// File: rtl/fetch_buf.sv
// One-entry last-fetch buffer: word-address tag, instruction data, valid bit.
module fetch_buf #(
  parameter int unsigned TAG_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_i,
  input  logic             inval_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [31:0]      fill_data_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_c_o,
  output logic [31:0]      data_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_c_o = valid_q & (tag_q == lookup_tag_i);
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_resp.sv
// Instruction-fetch response FSM between the IF stage and a word memory.
// Optional last-fetch buffer enabled by defining FETCH_BUF_EN.
module fetch_resp
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic         clk,
  input logic         rst,
  fetch_resp_if.slave bus
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              cs_q, cs_d;

  logic              issue_c;
  logic [ADDR_W-1:0] req_addr_c;
  logic              buf_fill_c, buf_inval_c, buf_hit_c;
  logic [31:0]       buf_data;

  assign issue_c    = bus.core_req & ~bus.core_flush;
  assign req_addr_c = bus.core_addr[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
    end
  end

  // Next state plus the registered response/memory-request values it implies.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    cs_d        = 1'b0;
    buf_fill_c  = 1'b0;
    buf_inval_c = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (issue_c) begin
          if (bus.core_addr[1:0] != 2'b00) begin
            state_d = RESP;
            valid_d = 1'b1;
            err_d   = 1'b1;
            instr_d = NOP;
          end else if (buf_hit_c) begin
            state_d = RESP;
            valid_d = 1'b1;
            instr_d = buf_data;
          end else begin
            state_d = REQ;
            addr_d  = req_addr_c;
            cnt_d   = '0;
            cs_d    = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.core_flush) begin
          // A flush racing the completion or the last wait cycle has nothing left to drain.
          if (bus.mem_ready || cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            state_d = DROP;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (bus.mem_ready) begin
          state_d    = RESP;
          valid_d    = 1'b1;
          instr_d    = bus.mem_rdata;
          buf_fill_c = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          valid_d     = 1'b1;
          err_d       = 1'b1;
          instr_d     = NOP;
          buf_inval_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          cs_d  = 1'b1;
        end
      end
      DROP: begin
        if (bus.mem_ready || cnt_q == CNT_LAST) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_BUF_EN
  fetch_buf #(.TAG_W(ADDR_W)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .fill_i      (buf_fill_c),
    .inval_i     (buf_inval_c),
    .fill_tag_i  (addr_q),
    .fill_data_i (bus.mem_rdata),
    .lookup_tag_i(req_addr_c),
    .hit_c_o     (buf_hit_c),
    .data_o      (buf_data)
  );
`else
  assign buf_hit_c = 1'b0;
  assign buf_data  = '0;
  logic unused_buf_c;
  assign unused_buf_c = ^{buf_fill_c, buf_inval_c};
`endif

  logic unused_addr_c;
  assign unused_addr_c = ^bus.core_addr[31:ADDR_W+2];

  // A same-cycle flush kills the response being presented.
  assign bus.core_valid = valid_q & ~bus.core_flush;
  assign bus.core_err   = err_q & ~bus.core_flush;
  assign bus.core_instr = instr_q;
  assign bus.mem_cs     = cs_q;
  assign bus.mem_addr   = addr_q;
  assign bus.core_stall = (state_q == REQ) | (state_q == DROP) | ((state_q == IDLE) & issue_c);

endmodule

// File: tb/tb_fetch_resp.sv
// Directed self-checking bench for fetch_resp (default and FETCH_BUF_EN builds).
module tb_fetch_resp;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  fetch_resp_if #(.ADDR_W(14)) bus ();

  fetch_resp #(.ADDR_W(14), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total += 1;
    if (got !== exp) begin
      n_bad += 1;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic flush,
                       input logic rdy, input logic [31:0] rdata);
    bus.core_req   = req;
    bus.core_addr  = addr;
    bus.core_flush = flush;
    bus.mem_ready  = rdy;
    bus.mem_rdata  = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_cnt;
    int vseen;
    logic seen;

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check_eq("rst_valid", 32'(bus.core_valid), 32'd0);
    check_eq("rst_err",   32'(bus.core_err),   32'd0);
    check_eq("rst_cs",    32'(bus.mem_cs),     32'd0);
    check_eq("rst_addr",  32'(bus.mem_addr),   32'h0);
    check_eq("rst_instr", bus.core_instr,      32'h0);
    check_eq("rst_stall", 32'(bus.core_stall), 32'd0);
    rst = 1'b0;
    tick();

    // Aligned fetch, memory answers one cycle after mem_cs.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("f1_stall_issue", 32'(bus.core_stall), 32'd1);
    tick();
    check_eq("f1_cs",        32'(bus.mem_cs),     32'd1);
    check_eq("f1_addr",      32'(bus.mem_addr),   32'h040);
    check_eq("f1_valid_c1",  32'(bus.core_valid), 32'd0);
    tick();
    check_eq("f1_cs_held",   32'(bus.mem_cs),     32'd1);
    check_eq("f1_addr_held", 32'(bus.mem_addr),   32'h040);
    check_eq("f1_stall_req", 32'(bus.core_stall), 32'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("f1_valid",     32'(bus.core_valid), 32'd1);
    check_eq("f1_instr",     bus.core_instr,      32'h0050_0093);
    check_eq("f1_err",       32'(bus.core_err),   32'd0);
    check_eq("f1_stall_rsp", 32'(bus.core_stall), 32'd0);
    check_eq("f1_cs_rsp",    32'(bus.mem_cs),     32'd0);
    tick();
    check_eq("f1_valid_pulse", 32'(bus.core_valid), 32'd0);

    // Misaligned address: no memory access, NOP with error.
    drive(1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("mis_cs",    32'(bus.mem_cs),     32'd0);
    check_eq("mis_valid", 32'(bus.core_valid), 32'd1);
    check_eq("mis_err",   32'(bus.core_err),   32'd1);
    check_eq("mis_instr", bus.core_instr,      NOP);
    tick();

    // Memory never answers: 15 request cycles then NOP with error.
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    cs_cnt = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.core_valid) seen = 1'b1;
      else if (bus.mem_cs) cs_cnt++;
    end
    check_eq("to_seen",   32'(seen),         32'd1);
    check_eq("to_cs_cnt", 32'(cs_cnt),       32'd15);
    check_eq("to_err",    32'(bus.core_err), 32'd1);
    check_eq("to_instr",  bus.core_instr,    NOP);
    check_eq("to_cs_off", 32'(bus.mem_cs),   32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // Flush in the second REQ cycle, memory answers three cycles later.
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check_eq("fl_cs_req2", 32'(bus.mem_cs), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("fl_cs_drop",    32'(bus.mem_cs),     32'd0);
    check_eq("fl_stall_drop", 32'(bus.core_stall), 32'd1);
    vseen = 0;
    for (int c = 3; c < 9; c++) begin
      bus.mem_ready = (c == 5);
      #1;
      if (bus.core_valid) vseen++;
      tick();
    end
    check_eq("fl_no_valid", 32'(vseen),          32'd0);
    check_eq("fl_stall_end", 32'(bus.core_stall), 32'd0);
    check_eq("fl_cs_end",   32'(bus.mem_cs),     32'd0);

    // Minimum latency, then a flush during RESP suppresses valid and ignores the request.
    drive(1'b1, 32'h400, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    check_eq("lat_cs",       32'(bus.mem_cs),     32'd1);
    check_eq("lat_valid_c1", 32'(bus.core_valid), 32'd0);
    tick();
    check_eq("lat_valid_c2", 32'(bus.core_valid), 32'd1);
    check_eq("lat_instr",    bus.core_instr,      32'hDEAD_BEEF);
    drive(1'b1, 32'h404, 1'b1, 1'b0, 32'h0);
    #1;
    check_eq("rflush_valid", 32'(bus.core_valid), 32'd0);
    check_eq("rflush_stall", 32'(bus.core_stall), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rflush_cs",    32'(bus.mem_cs),     32'd0);
    check_eq("rflush_v2",    32'(bus.core_valid), 32'd0);
    tick();

    // Same address fetched back-to-back.
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h0050_0093);
    tick();
    check_eq("rep_cs1", 32'(bus.mem_cs), 32'd1);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    check_eq("rep_valid1", 32'(bus.core_valid), 32'd1);
    check_eq("rep_instr1", bus.core_instr,      32'h0050_0093);
    check_eq("rep_cs_rsp", 32'(bus.mem_cs),     32'd0);
`ifdef FETCH_BUF_EN
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rep_cs2",    32'(bus.mem_cs),     32'd0);
    check_eq("rep_valid2", 32'(bus.core_valid), 32'd1);
    check_eq("rep_instr2", bus.core_instr,      32'h0050_0093);
`else
    tick();
    check_eq("rep_cs2",      32'(bus.mem_cs),     32'd1);
    check_eq("rep_valid_c1", 32'(bus.core_valid), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0050_0093;
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    check_eq("rep_valid2", 32'(bus.core_valid), 32'd1);
    check_eq("rep_instr2", bus.core_instr,      32'h0050_0093);
`endif
    tick();

    // Reset in the middle of a request abandons it.
    drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("mr_cs_req", 32'(bus.mem_cs), 32'd1);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("mr_cs",    32'(bus.mem_cs),     32'd0);
    check_eq("mr_addr",  32'(bus.mem_addr),   32'h0);
    check_eq("mr_valid", 32'(bus.core_valid), 32'd0);
    check_eq("mr_err",   32'(bus.core_err),   32'd0);
    check_eq("mr_instr", bus.core_instr,      32'h0);
    check_eq("mr_stall", 32'(bus.core_stall), 32'd0);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    vseen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      bus.mem_ready = 1'b0;
      if (bus.core_valid) vseen++;
    end
    check_eq("mr_no_late_valid", 32'(vseen),        32'd0);
    check_eq("mr_cs_late",       32'(bus.mem_cs),   32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
